// File: rtl/ntt_pkg.sv
// Shared defaults and state encoding for the guard_sampler rejection sampler.
package ntt_pkg;

    localparam int unsigned Q_DEFAULT  = 3329;
    localparam int unsigned N_DEFAULT  = 256;
    localparam int unsigned CW_DEFAULT = 12;
    localparam int unsigned SEED_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SKIP,
        ST_SAMPLE,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/guard_sampler.sv
// Rejection sampler: keeps PRNG words below Q and emits N indexed coefficients.
// Optional GUARD_SAMPLER_REJCNT_EN adds a saturating rejected-candidate counter (rej_cnt).
module guard_sampler
    import ntt_pkg::*;
#(
    parameter  int unsigned Q  = Q_DEFAULT,
    parameter  int unsigned N  = N_DEFAULT,
    parameter  int unsigned CW = CW_DEFAULT,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEED_W-1:0] seed,
    output logic              prng_ivalid,
    output logic [SEED_W-1:0] prng_seed,
    input  logic [SEED_W-1:0] prng_data,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic [CW-1:0]     coef_data,
    output logic [IW-1:0]     coef_idx,
    output logic              busy,
    output logic              done
`ifdef GUARD_SAMPLER_REJCNT_EN
    ,
    output logic [15:0]       rej_cnt
`endif
);

    localparam logic [CW-1:0] Q_CW  = CW'(Q);
    localparam logic [IW-1:0] LAST  = IW'(N - 1);

    state_e              state_q, state_d;
    logic [SEED_W-1:0]   seed_q, seed_d;
    logic                valid_q, valid_d;
    logic [CW-1:0]       data_q, data_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [IW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef GUARD_SAMPLER_REJCNT_EN
    logic [15:0]         rej_q, rej_d;
`endif

    logic [CW-1:0]       cand;
    logic                cand_ok;
    logic                xfer;
    logic                slot_free;

    generate
        if (CW < SEED_W) begin : g_unused_hi
            logic unused_prng_hi;
            assign unused_prng_hi = ^prng_data[SEED_W-1:CW];
        end
    endgenerate

    assign cand      = prng_data[CW-1:0];
    assign cand_ok   = cand < Q_CW;
    assign xfer      = valid_q & coef_ready;
    assign slot_free = ~valid_q | coef_ready;

    // Candidates are dropped rather than stalled: the PRNG advances every cycle.
    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
`ifdef GUARD_SAMPLER_REJCNT_EN
        rej_d   = rej_q;
`endif
        if (xfer) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    seed_d  = seed;
                    cnt_d   = '0;
`ifdef GUARD_SAMPLER_REJCNT_EN
                    rej_d   = '0;
`endif
                end
            end
            ST_LOAD:   state_d = ST_SKIP;
            ST_SKIP:   state_d = ST_SAMPLE;
            ST_SAMPLE: begin
                if (cand_ok && slot_free) begin
                    valid_d = 1'b1;
                    data_d  = cand;
                    idx_d   = cnt_q;
                    cnt_d   = cnt_q + IW'(1);
                    if (cnt_q == LAST) begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end
                end
`ifdef GUARD_SAMPLER_REJCNT_EN
                if (!cand_ok && rej_q != 16'hFFFF) begin
                    rej_d = rej_q + 16'd1;
                end
`endif
            end
            ST_DRAIN: begin
                if (xfer) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            seed_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef GUARD_SAMPLER_REJCNT_EN
            rej_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef GUARD_SAMPLER_REJCNT_EN
            rej_q   <= rej_d;
`endif
        end
    end

    assign prng_ivalid = (state_q == ST_LOAD);
    assign prng_seed   = seed_q;
    assign coef_valid  = valid_q;
    assign coef_data   = data_q;
    assign coef_idx    = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
`ifdef GUARD_SAMPLER_REJCNT_EN
    assign rej_cnt     = rej_q;
`endif

endmodule

// File: tb/tb_guard_sampler.sv
// Testbench for guard_sampler: models the upstream PRNG and predicts every
// coefficient transfer from the acceptance rules with a cycle-level scoreboard.
`timescale 1ns/1ps
module tb_guard_sampler;
   import ntt_pkg::*;

   localparam int N  = N_DEFAULT;
   localparam int Q  = Q_DEFAULT;
   localparam int CW = CW_DEFAULT;
   localparam int IW = $clog2(N);

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [15:0]   seed;
   logic          prngIvalid;
   logic [15:0]   prngSeed;
   logic [15:0]   prngData;
   logic          coefValid;
   logic          coefReady;
   logic [CW-1:0] coefData;
   logic [IW-1:0] coefIdx;
   logic          busy;
   logic          done;
`ifdef GUARD_SAMPLER_REJCNT_EN
   logic [15:0]   rejCnt;
`endif

   int checkCount = 0;
   int errorCount = 0;
   int capture[N];

   // Free-running clock, 10 ns period
   always #5 clk = ~clk;

   guard_sampler dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .seed        (seed),
      .prng_ivalid (prngIvalid),
      .prng_seed   (prngSeed),
      .prng_data   (prngData),
      .coef_valid  (coefValid),
      .coef_ready  (coefReady),
      .coef_data   (coefData),
      .coef_idx    (coefIdx),
      .busy        (busy),
      .done        (done)
`ifdef GUARD_SAMPLER_REJCNT_EN
      ,
      .rej_cnt     (rejCnt)
`endif
   );

   // Galois LFSR step of the external PRNG (seed 1 doubles up to 0x8000, then wraps to 0x00AF)
   function automatic logic [15:0] lfsrNext(input logic [15:0] s);
      return {s[14:0], 1'b0} ^ (s[15] ? 16'h00AF : 16'h0000);
   endfunction

   // Upstream PRNG model: loads on the strobe, otherwise advances; forceEn overrides the word
   logic [15:0] lfsrState = 16'h0000;
   logic        forceEn   = 1'b0;
   logic [15:0] forceVal  = 16'h0000;
   always @(posedge clk) lfsrState <= prngIvalid ? prngSeed : lfsrNext(lfsrState);
   assign prngData = forceEn ? forceVal : lfsrState;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Runs one sampling job and checks it cycle by cycle against the reference model.
   // readyMode: 0 = always ready, 1 = random ready, 2 = ready held low 10 cycles after first valid.
   // abortIdx >= 0 asserts reset (with start and ready) once that index is on the output.
   task automatic applyStimulus(input logic [15:0] runSeed, input int readyMode, input int abortIdx,
                                input bit pulseStartMid, input bit forceRej, input bit startInDone);
      logic [15:0] word;
      bit mValid, sampling, doneNext, xfer, rdy;
      int mData, mIdx, accCount, xferCount, rejCount, holdCycles, cand;

      @(negedge clk);
      seed  = runSeed;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seed  = 16'($urandom);
      checkOutput("load_ivalid", 32'(prngIvalid), 32'd1);
      checkOutput("load_seed", 32'(prngSeed), 32'(runSeed));
      checkOutput("load_busy", 32'(busy), 32'd1);
      @(negedge clk);
      checkOutput("skip_ivalid", 32'(prngIvalid), 32'd0);
      checkOutput("skip_valid", 32'(coefValid), 32'd0);
      @(negedge clk);

      word = runSeed;
      mValid = 0; mData = 0; mIdx = 0; sampling = 1; doneNext = 0;
      accCount = 0; xferCount = 0; rejCount = 0; holdCycles = 0;

      for (int iter = 0; iter < 20 * N && !doneNext; iter++) begin
         word = lfsrNext(word);
         checkOutput("coef_valid", 32'(coefValid), 32'(mValid));
         if (mValid) begin
            checkOutput("coef_data", 32'(coefData), 32'(mData));
            checkOutput("coef_idx", 32'(coefIdx), 32'(mIdx));
         end
         checkOutput("run_busy", 32'(busy), 32'd1);
         checkOutput("run_ivalid", 32'(prngIvalid), 32'd0);
         checkOutput("run_done", 32'(done), 32'd0);
`ifdef GUARD_SAMPLER_REJCNT_EN
         checkOutput("rej_cnt", 32'(rejCnt), 32'(rejCount));
`endif

         if (abortIdx >= 0 && mValid && mIdx == abortIdx) begin
            rst = 1'b1; start = 1'b1; coefReady = 1'b1;
            @(negedge clk);
            rst = 1'b0; start = 1'b0;
            checkOutput("abort_valid", 32'(coefValid), 32'd0);
            checkOutput("abort_idx", 32'(coefIdx), 32'd0);
            checkOutput("abort_data", 32'(coefData), 32'd0);
            checkOutput("abort_busy", 32'(busy), 32'd0);
            checkOutput("abort_done", 32'(done), 32'd0);
            checkOutput("abort_seed", 32'(prngSeed), 32'd0);
            checkOutput("abort_ivalid", 32'(prngIvalid), 32'd0);
            return;
         end

         case (readyMode)
            0: rdy = 1;
            1: rdy = ($urandom_range(9) < 7);
            default: begin
               if (mValid && holdCycles < 10) begin
                  rdy = 0;
                  holdCycles++;
               end else begin
                  rdy = 1;
               end
            end
         endcase
         coefReady = rdy;

         forceEn  = forceRej && (iter == 3 || iter == 4);
         forceVal = (iter == 3) ? 16'd3328 : 16'd3329;
         start    = pulseStartMid && (iter == 20);

         cand = forceEn ? int'(forceVal[CW-1:0]) : int'(word[CW-1:0]);
         xfer = mValid && rdy;
         if (xfer) begin
            capture[mIdx] = mData;
            xferCount++;
            if (mIdx == N - 1) doneNext = 1;
         end
         if (sampling && cand < Q && (!mValid || rdy)) begin
            mValid = 1; mData = cand; mIdx = accCount;
            accCount++;
            if (accCount == N) sampling = 0;
         end else if (xfer) begin
            mValid = 0;
         end
         if (sampling && cand >= Q && rejCount < 65535) rejCount++;
         @(negedge clk);
      end
      forceEn = 1'b0;
      start   = 1'b0;

      checkOutput("xfer_count", 32'(xferCount), 32'(N));
      checkOutput("done_pulse", 32'(done), 32'd1);
      checkOutput("done_busy", 32'(busy), 32'd1);
      checkOutput("done_valid", 32'(coefValid), 32'd0);
      start = startInDone;
      @(negedge clk);
      start = 1'b0;
      checkOutput("idle_done", 32'(done), 32'd0);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      @(negedge clk);
      checkOutput("idle_busy2", 32'(busy), 32'd0);
      checkOutput("idle_ivalid", 32'(prngIvalid), 32'd0);
   endtask

   // Abort guard so the bench always ends
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset, directed vectors, randomized runs, then summary
   initial begin
      int seq1[16] = '{2, 4, 8, 16, 32, 64, 128, 256, 512, 1024, 2048, 0, 0, 0, 0, 175};
      rst = 1'b1; start = 1'b0; seed = 16'h0000; coefReady = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_valid", 32'(coefValid), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_ivalid", 32'(prngIvalid), 32'd0);
      checkOutput("rst_seed", 32'(prngSeed), 32'd0);
      checkOutput("rst_data", 32'(coefData), 32'd0);
      checkOutput("rst_idx", 32'(coefIdx), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;

      $display("[TB] seed 1, always ready");
      applyStimulus(16'h0001, 0, -1, 0, 0, 0);
      for (int i = 0; i < 16; i++) checkOutput($sformatf("seq1_%0d", i), 32'(capture[i]), 32'(seq1[i]));

      $display("[TB] seed 0, always ready, start during DONE");
      applyStimulus(16'h0000, 0, -1, 0, 0, 1);
      checkOutput("zero_first", 32'(capture[0]), 32'd0);
      checkOutput("zero_last", 32'(capture[N-1]), 32'd0);

      $display("[TB] seed 1, backpressure after first valid");
      applyStimulus(16'h0001, 2, -1, 0, 0, 0);
      checkOutput("hold_first", 32'(capture[0]), 32'd2);
      checkOutput("hold_second", 32'(capture[1]), 32'd0);

      $display("[TB] reset while idx 40 is pending");
      applyStimulus(16'h0001 | 16'($urandom), 0, 40, 0, 0, 0);

      for (int r = 0; r < 3; r++) begin
         $display("[TB] random run %0d", r);
         applyStimulus(16'($urandom), 1, -1, r == 0, 0, 0);
      end

      $display("[TB] forced boundary candidates 3328 and 3329");
      applyStimulus(16'h0000, 0, -1, 0, 1, 0);
      checkOutput("bound_accept", 32'(capture[3]), 32'd3328);
      checkOutput("bound_reject", 32'(capture[4]), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
